lcd_timing_gen: RTL

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 48 ++++
 rtl/lcd_sync_counter.sv | 45 ++++
 rtl/lcd_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and helpers for the LCD timing generator.
// Default panel timing is 800x480 with a 928x525 total raster.
package lcd_timing_pkg;

  localparam int unsigned COORD_W       = 10;

  localparam int unsigned DEF_H_ACTIVE  = 800;
  localparam int unsigned DEF_H_FP      = 40;
  localparam int unsigned DEF_H_SYNC    = 48;
  localparam int unsigned DEF_H_BP      = 40;

  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 13;
  localparam int unsigned DEF_V_SYNC    = 3;
  localparam int unsigned DEF_V_BP      = 29;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Clocks by which fetch coordinates lead the displayed coordinates.
  localparam int unsigned PREFETCH_LEAD = 2;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Advance a raster position by 'steps' pixels, wrapping lines and frames.
  function automatic pos_t pos_advance(input pos_t p, input int unsigned steps,
                                       input int unsigned h_total,
                                       input int unsigned v_total);
    pos_t r;
    r = p;
    for (int unsigned i = 0; i < steps; i++) begin
      if (r.x == COORD_W'(h_total - 1)) begin
        r.x = '0;
        if (r.y == COORD_W'(v_total - 1)) r.y = '0;
        else                              r.y = r.y + 1'b1;
      end else begin
        r.x = r.x + 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while cnt_en is high,
// flags the wrap, and decodes the active and sync windows of the current count.
module lcd_sync_counter #(
  parameter int unsigned W          = 10,
  parameter int unsigned TOTAL      = 928,
  parameter int unsigned ACTIVE     = 800,
  parameter int unsigned SYNC_START = 840,
  parameter int unsigned SYNC_LEN   = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cnt_en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_active,
  output logic         in_sync
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI = W'(SYNC_START + SYNC_LEN);

  logic [W-1:0] cnt_q, cnt_d;

  // Next-count and wrap decode.
  always_comb begin
    wrap  = cnt_en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (cnt_en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign in_active = (cnt_q < ACT_END);
  assign in_sync   = (cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: DE, active-low syncs, pixel coordinates,
// frame-start pulse and vertical blank, all registered.
// Optional macro LCD_TIMING_PREFETCH_EN adds fetch_x/fetch_y/fetch_valid,
// which lead the displayed coordinates by PREFETCH_LEAD enabled clocks.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               lcd_de,
  output logic               lcd_hsync,
  output logic               lcd_vsync,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               frame_start,
  output logic               vblank
`ifdef LCD_TIMING_PREFETCH_EN
  ,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               fetch_valid
`endif
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters hold the position that the output registers will show after
  // the next enabled edge, so the registered outputs line up with the count
  // and the first clock after reset already shows pixel (0,0).
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic               h_act, v_act, h_sync, v_sync;

  lcd_sync_counter #(
    .W(COORD_W), .TOTAL(H_TOT), .ACTIVE(H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
  ) u_h_cnt (
    .clk(clk), .rst(rst), .cnt_en(enable),
    .cnt(h_cnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
  );

  lcd_sync_counter #(
    .W(COORD_W), .TOTAL(V_TOT), .ACTIVE(V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
  ) u_v_cnt (
    .clk(clk), .rst(rst), .cnt_en(h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
  );

  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  logic               de_q, de_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic               fs_q, fs_d;
  logic               vblank_q, vblank_d;

  // Output decode: live raster while enabled, blanked with idle syncs on hold.
  always_comb begin
    de_d     = 1'b0;
    hsync_d  = 1'b1;
    vsync_d  = 1'b1;
    pos_x_d  = '0;
    pos_y_d  = '0;
    fs_d     = 1'b0;
    vblank_d = vblank_q;
    if (enable) begin
      de_d     = h_act && v_act;
      hsync_d  = ~h_sync;
      vsync_d  = ~v_sync;
      pos_x_d  = (h_act && v_act) ? h_cnt : '0;
      pos_y_d  = (h_act && v_act) ? v_cnt : '0;
      fs_d     = (h_cnt == '0) && (v_cnt == '0);
      vblank_d = ~v_act;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q     <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      fs_q     <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      fs_q     <= fs_d;
      vblank_q <= vblank_d;
    end
  end

  assign lcd_de      = de_q;
  assign lcd_hsync   = hsync_q;
  assign lcd_vsync   = vsync_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign frame_start = fs_q;
  assign vblank      = vblank_q;

`ifdef LCD_TIMING_PREFETCH_EN
  pos_t               ahead;
  logic               ahead_act;
  logic [COORD_W-1:0] fetch_x_q, fetch_x_d;
  logic [COORD_W-1:0] fetch_y_q, fetch_y_d;
  logic               fetch_valid_q, fetch_valid_d;

  // Fetch decode: the counter already leads the outputs by one, so stepping it
  // by PREFETCH_LEAD more yields the pixel displayed PREFETCH_LEAD clocks later.
  always_comb begin
    ahead         = pos_advance(pos_t'{x: h_cnt, y: v_cnt}, PREFETCH_LEAD, H_TOT, V_TOT);
    ahead_act     = (ahead.x < COORD_W'(H_ACTIVE)) && (ahead.y < COORD_W'(V_ACTIVE));
    fetch_x_d     = fetch_x_q;
    fetch_y_d     = fetch_y_q;
    fetch_valid_d = fetch_valid_q;
    if (enable) begin
      fetch_x_d     = ahead_act ? ahead.x : '0;
      fetch_y_d     = ahead_act ? ahead.y : '0;
      fetch_valid_d = ahead_act;
    end
  end

  // Fetch registers; frozen during hold so the lead is kept in enabled clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;
  assign fetch_valid = fetch_valid_q;
`endif

endmodule
